// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control sequencer:
// state encoding, RV32I major opcodes, the decoded control word and trap causes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  // Register-file write-data source
  localparam logic [1:0] RDV_PC4 = 2'b00;
  localparam logic [1:0] RDV_ALU = 2'b01;
  localparam logic [1:0] RDV_IMM = 2'b10;
  localparam logic [1:0] RDV_MEM = 2'b11;

  // Trap causes
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       sel_op1;    // 1 = rs1v, 0 = PC
    logic       sel_op2;    // 1 = rs2v, 0 = immediate
    logic [1:0] sel_rdv;    // rd source, RDV_*
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;    // JAL / JALR: next PC comes from the ALU
    logic       legal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/multicycle_decoder.sv
// Combinational opcode decoder: maps the 7-bit RV32I major opcode onto the
// control word consumed by the sequencer. Unlisted opcodes decode as illegal.
module multicycle_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  // Opcode to control-word lookup
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a bit unassigned; otherwise synthesis infers a latch.
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ALUR: begin
        ctrl.legal   = 1'b1;
        ctrl.sel_op1 = 1'b1;
        ctrl.sel_op2 = 1'b1;
        ctrl.sel_rdv = RDV_ALU;
      end
      OP_ALUI: begin
        ctrl.legal   = 1'b1;
        ctrl.sel_op1 = 1'b1;
        ctrl.sel_rdv = RDV_ALU;
      end
      OP_LUI: begin
        ctrl.legal   = 1'b1;
        ctrl.sel_rdv = RDV_IMM;
      end
      OP_AUIPC: begin
        ctrl.legal   = 1'b1;
        ctrl.sel_rdv = RDV_ALU;
      end
      OP_JAL: begin
        ctrl.legal   = 1'b1;
        ctrl.is_jump = 1'b1;
        ctrl.sel_rdv = RDV_PC4;
      end
      OP_JALR: begin
        ctrl.legal   = 1'b1;
        ctrl.is_jump = 1'b1;
        ctrl.sel_op1 = 1'b1;
        ctrl.sel_rdv = RDV_PC4;
      end
      OP_LOAD: begin
        ctrl.legal   = 1'b1;
        ctrl.is_load = 1'b1;
        ctrl.sel_op1 = 1'b1;
        ctrl.sel_rdv = RDV_MEM;
      end
      OP_STORE: begin
        ctrl.legal    = 1'b1;
        ctrl.is_store = 1'b1;
        ctrl.sel_op1  = 1'b1;
      end
      OP_BRANCH: begin
        // ALU forms the target PC + imm; the comparator result arrives separately
        ctrl.legal     = 1'b1;
        ctrl.is_branch = 1'b1;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control sequencer: START/FETCH/DECODE/EXECUTE/MEM/
// WRITEBACK/TRAP. Handshakes with variable-latency memory, traps illegal
// opcodes and memory stalls longer than STALL_TIMEOUT (0 = never), and pulses
// retire on the last cycle of every instruction.
// Optional build macro MULTICYCLE_PERF_COUNTERS_EN adds cycle/instret counters;
// without it both counter ports are tied to zero.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             sel_addr,
  output logic             ir_we,
  output logic             pc_we,
  output logic             sel_pc_next,
  output logic             reg_we,
  output logic             sel_op1,
  output logic             sel_op2,
  output logic [1:0]       sel_rdv,
  output logic             retire,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  // Wait counter only has to reach STALL_TIMEOUT-1; the trap fires on the
  // cycle it would step to STALL_TIMEOUT.
  localparam int WAIT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_TIMEOUT - 1);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_dec;
  logic [1:0]        trap_q, trap_d;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_hit;
  logic              mem_state;

  multicycle_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (ctrl_dec)
  );

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM);
  // A mem_ready arriving on the timeout cycle wins over the trap.
  assign timeout_hit = (STALL_TIMEOUT != 0) && (wait_q == WAIT_LAST) && !mem_ready;

  // Next-state and trap-cause selection
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!ctrl_dec.legal) begin
          state_d = S_TRAP;
          trap_d  = TRAP_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!ctrl_q.legal) begin
          // Unreachable: DECODE never advances on an illegal word
          state_d = S_TRAP;
          trap_d  = TRAP_ILLEGAL;
        end else if (ctrl_q.is_branch) begin
          state_d = S_FETCH;
        end else if (ctrl_q.is_load || ctrl_q.is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = ctrl_q.is_store ? S_FETCH : S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = TRAP_TIMEOUT;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_START;
    endcase
  end

  // Datapath control decoded from the current state and the latched control word
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    sel_addr    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    sel_pc_next = 1'b0;
    reg_we      = 1'b0;
    sel_op1     = 1'b0;
    sel_op2     = 1'b0;
    sel_rdv     = RDV_PC4;
    retire      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_EXECUTE: begin
        sel_op1 = ctrl_q.sel_op1;
        sel_op2 = ctrl_q.sel_op2;
        if (ctrl_q.is_branch) begin
          pc_we       = 1'b1;
          sel_pc_next = branch_taken;
          retire      = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        sel_addr = 1'b1;
        mem_we   = ctrl_q.is_store;
        if (ctrl_q.is_store && mem_ready) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_we      = 1'b1;
        sel_rdv     = ctrl_q.sel_rdv;
        pc_we       = 1'b1;
        sel_pc_next = ctrl_q.is_jump;
        retire      = 1'b1;
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

  // State, control word, trap cause and memory wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the control word is a handful of flops feeding output decode,
      // so it is reset like the rest of the control state (a RAM would not be).
      state_q <= S_START;
      ctrl_q  <= CTRL_NOP;
      trap_q  <= TRAP_NONE;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      trap_q  <= trap_d;
      if (state_q == S_DECODE) begin
        ctrl_q <= ctrl_dec;
      end
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
        wait_q <= '0;
      end else if (mem_state && !mem_ready) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
    end
  end

  assign state      = state_q;
  assign trap_cause = trap_q;

`ifdef MULTICYCLE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  // Performance counters: saturating, frozen in START and TRAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else if ((state_q != S_START) && (state_q != S_TRAP)) begin
      if (cyc_q != '1) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if (retire && (ins_q != '1)) begin
        ins_q <= ins_q + CNT_W'(1);
      end
    end
  end

  assign cycle_count   = cyc_q;
  assign instret_count = ins_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule
